// File: rtl/tiny_fpga_cfg_pkg.sv
// Shared types and helpers for the tiny FPGA configuration loader.
package tiny_fpga_cfg_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} cfg_load_state_e;

  function automatic int cfg_beats(input int cfg_bits, input int data_width);
    return cfg_bits / data_width;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle (no tkeep/tuser) used to carry the configuration bitstream.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 1
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/cfg_shift_reg.sv
// MSB-first shadow shift register: new beats enter at the LSB end.
module cfg_shift_reg #(
  parameter int DATA_WIDTH = 1,
  parameter int CFG_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [CFG_BITS-1:0]   shifted
);

  logic [CFG_BITS-1:0] shadow;

  // The post-shift value is exported so the caller can commit it on the same
  // edge that accepts the final beat.
  generate
    if (CFG_BITS == DATA_WIDTH) begin : g_single_beat
      assign shifted = din;
    end else begin : g_multi_beat
      assign shifted = {shadow[CFG_BITS-DATA_WIDTH-1:0], din};
    end
  endgenerate

  // NOTE: the shadow is a plain register bank, so it takes the async reset like
  // any other flop; it is not a RAM and gains nothing by skipping reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (shift_en) begin
      shadow <= shifted;
    end
  end

endmodule

// File: rtl/tiny_fpga_cfg_loader.sv
// Configuration loader: shifts a framed bitstream into a shadow register and
// commits it to cfg_word only when the frame length matches exactly.
module tiny_fpga_cfg_loader
  import tiny_fpga_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int CFG_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg,
  axi_stream_if.slave         cfg_bitstream,
  output logic [CFG_BITS-1:0] cfg_word,
  output logic                cfg_ready,
  output logic                cfg_error
);

  localparam int BEATS = cfg_beats(CFG_BITS, DATA_WIDTH);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if ((DATA_WIDTH < 1) || (CFG_BITS % DATA_WIDTH != 0)) begin : g_bad_params
      $error("CFG_BITS must be a non-zero multiple of DATA_WIDTH");
    end
  endgenerate

  cfg_load_state_e     state;
  logic [CNT_W-1:0]    count;
  logic [CFG_BITS-1:0] shifted;
  logic                beat;

  // tready depends on registered state only, never on tvalid.
  assign cfg_bitstream.tready = (state == LOAD) || (state == ERROR);
  assign beat                 = cfg_bitstream.tvalid && cfg_bitstream.tready;

  cfg_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .CFG_BITS   (CFG_BITS)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (beat),
    .din      (cfg_bitstream.tdata),
    .shifted  (shifted)
  );

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values of state/count, exactly like the hardware flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      cfg_word  <= '0;
      cfg_ready <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg) begin
            state     <= LOAD;
            count     <= '0;
            cfg_ready <= 1'b0;
            cfg_error <= 1'b0;
          end
        end
        LOAD: begin
          // Abort wins over any beat presented in the same cycle.
          if (!cfg) begin
            state <= IDLE;
          end else if (beat) begin
            count <= count + CNT_W'(1);
            if (count == LAST_CNT) begin
              if (cfg_bitstream.tlast) begin
                state     <= DONE;
                cfg_word  <= shifted;
                cfg_ready <= 1'b1;
              end else begin
                state     <= ERROR;
                cfg_error <= 1'b1;
              end
            end else if (cfg_bitstream.tlast) begin
              state     <= ERROR;
              cfg_error <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!cfg) state <= IDLE;
        end
        ERROR: begin
          if (!cfg) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_fpga_cfg_loader.sv
// Randomised self-checking bench for tiny_fpga_cfg_loader (1-bit and 4-bit beats).
module tb_tiny_fpga_cfg_loader;

  localparam int BEATS = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg;
  logic cfg4;
  logic [15:0] cfg_word1, cfg_word4;
  logic cfg_ready1, cfg_ready4, cfg_error1, cfg_error4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the DATA_WIDTH=1 loader's visible outputs.
  int exp_word  = 0;
  int exp_ready = 0;
  int exp_error = 0;

  always #5 clk = ~clk;

  axi_stream_if #(.DATA_WIDTH(1)) s1 ();
  axi_stream_if #(.DATA_WIDTH(4)) s4 ();

  tiny_fpga_cfg_loader #(.DATA_WIDTH(1), .CFG_BITS(16)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (cfg),
    .cfg_bitstream (s1.slave),
    .cfg_word      (cfg_word1),
    .cfg_ready     (cfg_ready1),
    .cfg_error     (cfg_error1)
  );

  tiny_fpga_cfg_loader #(.DATA_WIDTH(4), .CFG_BITS(16)) dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (cfg4),
    .cfg_bitstream (s4.slave),
    .cfg_word      (cfg_word4),
    .cfg_ready     (cfg_ready4),
    .cfg_error     (cfg_error4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".word"},  cfg_word1,  exp_word[15:0]);
    check({tag, ".ready"}, cfg_ready1, exp_ready[0]);
    check({tag, ".error"}, cfg_error1, exp_error[0]);
  endtask

  // One load attempt on the 1-bit loader. Sends n_beats bits of value MSB first,
  // tlast on the last one if with_tlast; abort_after>0 drops cfg after that many beats.
  task automatic run_load(input logic [15:0] value, input int n_beats,
                          input bit with_tlast, input int abort_after);
    int acc  = 0;
    int sent = 0;
    @(negedge clk) cfg = 1'b1;
    @(negedge clk);
    check("entry.tready", s1.tready, 1'b1);
    exp_ready = 0;
    exp_error = 0;
    check_outputs("entry");
    for (int i = 0; i < n_beats; i++) begin
      if (abort_after > 0 && i == abort_after) break;
      repeat ($urandom_range(0, 2)) begin
        s1.tvalid = 1'b0;
        @(negedge clk);
        check("gap.tready", s1.tready, 1'b1);
      end
      s1.tvalid = 1'b1;
      s1.tdata  = value[15-i];
      s1.tlast  = with_tlast && (i == n_beats - 1);
      acc       = (acc * 2) + int'(value[15-i]);
      sent++;
      @(negedge clk);
    end
    s1.tvalid = 1'b0;
    s1.tlast  = 1'b0;

    if (abort_after > 0) begin
      // A beat presented in the abort cycle must be swallowed harmlessly.
      cfg       = 1'b0;
      s1.tvalid = 1'b1;
      s1.tdata  = 1'($urandom);
      s1.tlast  = 1'b1;
      @(negedge clk);
      s1.tvalid = 1'b0;
      s1.tlast  = 1'b0;
      check("abort.tready", s1.tready, 1'b0);
      check_outputs("abort");
    end else if (with_tlast && sent == BEATS) begin
      exp_word  = acc;
      exp_ready = 1;
      check("done.tready", s1.tready, 1'b0);
      check_outputs("done");
    end else begin
      exp_error = 1;
      check_outputs("error");
      repeat (3) begin
        s1.tvalid = 1'b1;
        s1.tdata  = 1'($urandom);
        s1.tlast  = 1'($urandom);
        @(negedge clk);
        check("drain.tready", s1.tready, 1'b1);
      end
      s1.tvalid = 1'b0;
      s1.tlast  = 1'b0;
      check_outputs("drain");
    end

    // cfg still high must not restart a load.
    if (abort_after == 0) begin
      @(negedge clk);
      check("hold.tready", s1.tready, (exp_error != 0) ? 1'b1 : 1'b0);
      check_outputs("hold");
    end
    cfg = 1'b0;
    @(negedge clk);
    check("idle.tready", s1.tready, 1'b0);
    check_outputs("idle");
  endtask

  initial begin
    logic [15:0] rv;
    logic [3:0]  nib [4];
    int          kind;
    rst_n     = 1'b0;
    cfg       = 1'b0;
    cfg4      = 1'b0;
    s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0;
    s4.tvalid = 1'b0; s4.tdata = '0; s4.tlast = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check("reset.tready", s1.tready, 1'b0);
    check("reset.word4", cfg_word4, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: 0xA5C3 over 1-bit beats.
    run_load(16'hA5C3, 16, 1'b1, 0);

    // Directed: 0xBEEF over 4-bit beats with gaps 0..3.
    nib[0] = 4'hB; nib[1] = 4'hE; nib[2] = 4'hE; nib[3] = 4'hF;
    @(negedge clk) cfg4 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      repeat (i) begin
        s4.tvalid = 1'b0;
        @(negedge clk);
        check("w4.gap.tready", s4.tready, 1'b1);
      end
      check("w4.beat.tready", s4.tready, 1'b1);
      s4.tvalid = 1'b1;
      s4.tdata  = nib[i];
      s4.tlast  = (i == 3);
      @(negedge clk);
    end
    s4.tvalid = 1'b0;
    s4.tlast  = 1'b0;
    check("w4.word", cfg_word4, 16'hBEEF);
    check("w4.ready", cfg_ready4, 1'b1);
    check("w4.error", cfg_error4, 1'b0);
    check("w4.tready", s4.tready, 1'b0);
    cfg4 = 1'b0;

    // Directed: good 0xBEEF, short frame, missing tlast, correct 0x1234, abort.
    run_load(16'hBEEF, 16, 1'b1, 0);
    run_load(16'h5555, 10, 1'b1, 0);
    run_load(16'hFFFF, 16, 1'b0, 0);
    run_load(16'h1234, 16, 1'b1, 0);
    run_load(16'hC0DE, 16, 1'b1, 5);

    // Randomised loads against the model.
    for (int t = 0; t < 24; t++) begin
      rv   = 16'($urandom);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       run_load(rv, 16, 1'b1, 0);
        1:       run_load(rv, $urandom_range(1, 15), 1'b1, 0);
        2:       run_load(rv, 16, 1'b0, 0);
        default: run_load(rv, 16, 1'b1, $urandom_range(1, 15));
      endcase
    end

    // Reset in the middle of a load clears everything immediately.
    run_load(16'h0F0F, 16, 1'b1, 0);
    @(negedge clk) cfg = 1'b1;
    repeat (6) begin
      s1.tvalid = 1'b1;
      s1.tdata  = 1'($urandom);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_word  = 0;
    exp_ready = 0;
    exp_error = 0;
    check_outputs("midreset");
    check("midreset.tready", s1.tready, 1'b0);
    check("midreset.word4", cfg_word4, 16'h0);
    s1.tvalid = 1'b0;
    cfg       = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_load(16'h9A7E, 16, 1'b1, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
